stack_cpu_core: RTL and testbench

- Parametrised successor to the fixed 4-instruction LED sequencer: an 8-bit-opcode stack machine executing from an external program ROM at a programmable step rate.
- Adds a data stack, arithmetic, conditional and unconditional jumps, an output register and halt/fault handling.
- Sits between the program ROM (combinational read) and board I/O; the top drives LED from OUT[0].

---
 rtl/stack_cpu_core.sv | 171 +++++++++++++++++
 tb/tb_stack_cpu_core.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_cpu_core.sv
// Stack machine core: fetches 8-bit opcodes from an external combinational ROM
// at a programmable step rate, with a data stack, output register and sticky halt/fault.
module stack_cpu_core #(
  parameter int DATA_W      = 8,
  parameter int STACK_DEPTH = 8,
  parameter int PROG_AW     = 4,
  parameter int STEP_DIV    = 4000000
) (
  input  logic                               CLK,
  input  logic                               RESETN,
  input  logic                               ENABLE,
  output logic [PROG_AW-1:0]                 PROG_ADDR,
  input  logic [7:0]                         PROG_DATA,
  output logic [DATA_W-1:0]                  OUT,
  output logic                               OUT_STROBE,
  output logic                               HALTED,
  output logic                               FAULT,
  output logic [1:0]                         FAULT_CODE,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   STACK_COUNT
);

  localparam int SC_W  = $clog2(STACK_DEPTH + 1);
  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic [SC_W-1:0]  SC_FULL  = SC_W'(STACK_DEPTH);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HALT  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t             state;
  logic [PROG_AW-1:0] pc;
  logic [CNT_W-1:0]   step_cnt;
  logic [SC_W-1:0]    count;
  logic [DATA_W-1:0]  out_reg;
  logic               strobe;
  logic [1:0]         fault_code;

  // Entry 0 is always the top of stack; pushes shift down, pops shift up.
  logic [DATA_W-1:0]  stk [STACK_DEPTH];

  logic               op_illegal, op_halt, op_out, op_add, op_dup;
  logic               op_drop, op_swap, op_push, op_jmp, op_jz;
  logic [1:0]         need;
  logic               grows;
  logic [1:0]         fault_next;
  logic               step_fire;
  logic               jz_taken;
  logic [PROG_AW-1:0] jump_target;
  logic [DATA_W-1:0]  imm;

  assign step_fire   = ENABLE && (state == S_RUN) && (step_cnt == CNT_LAST);
  assign jump_target = PROG_AW'(PROG_DATA[5:0]);
  assign imm         = DATA_W'(PROG_DATA[5:0]);
  assign jz_taken    = (stk[0] == '0);

  always_comb begin
    op_illegal = 1'b0;
    op_halt    = 1'b0;
    op_out     = 1'b0;
    op_add     = 1'b0;
    op_dup     = 1'b0;
    op_drop    = 1'b0;
    op_swap    = 1'b0;
    op_push    = 1'b0;
    op_jmp     = 1'b0;
    op_jz      = 1'b0;
    need       = 2'd0;
    grows      = 1'b0;
    unique case (PROG_DATA[7:6])
      2'b00: begin
        case (PROG_DATA[5:0])
          6'h00: begin end
          6'h01: op_halt = 1'b1;
          6'h02: begin op_out  = 1'b1; need = 2'd1; end
          6'h03: begin op_add  = 1'b1; need = 2'd2; end
          6'h04: begin op_dup  = 1'b1; need = 2'd1; grows = 1'b1; end
          6'h05: begin op_drop = 1'b1; need = 2'd1; end
          6'h06: begin op_swap = 1'b1; need = 2'd2; end
          default: op_illegal = 1'b1;
        endcase
      end
      2'b01: begin
        op_push = 1'b1;
        grows   = 1'b1;
      end
      2'b10: op_jmp = 1'b1;
      default: begin
        op_jz = 1'b1;
        need  = 2'd1;
      end
    endcase

    // Legality first, then underflow, then overflow.
    fault_next = 2'b00;
    if (op_illegal)
      fault_next = 2'b11;
    else if (count < SC_W'(need))
      fault_next = 2'b10;
    else if (grows && (count == SC_FULL))
      fault_next = 2'b01;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state      <= S_RUN;
      pc         <= '0;
      step_cnt   <= '0;
      count      <= '0;
      out_reg    <= '0;
      strobe     <= 1'b0;
      fault_code <= 2'b00;
      for (int i = 0; i < STACK_DEPTH; i++)
        stk[i] <= '0;
    end else begin
      strobe <= 1'b0;
      if (ENABLE && (state == S_RUN))
        step_cnt <= step_fire ? '0 : step_cnt + CNT_W'(1);

      if (step_fire) begin
        if (fault_next != 2'b00) begin
          state      <= S_FAULT;
          fault_code <= fault_next;
        end else if (op_halt) begin
          state <= S_HALT;
        end else begin
          pc <= pc + PROG_AW'(1);
          if (op_out) begin
            out_reg <= stk[0];
            strobe  <= 1'b1;
            count   <= count - SC_W'(1);
            for (int i = 0; i < STACK_DEPTH - 1; i++)
              stk[i] <= stk[i+1];
          end else if (op_add) begin
            stk[0] <= stk[0] + stk[1];
            count  <= count - SC_W'(1);
            for (int i = 1; i < STACK_DEPTH - 1; i++)
              stk[i] <= stk[i+1];
          end else if (op_dup || op_push) begin
            stk[0] <= op_dup ? stk[0] : imm;
            count  <= count + SC_W'(1);
            for (int i = 1; i < STACK_DEPTH; i++)
              stk[i] <= stk[i-1];
          end else if (op_drop || op_jz) begin
            count <= count - SC_W'(1);
            for (int i = 0; i < STACK_DEPTH - 1; i++)
              stk[i] <= stk[i+1];
            if (op_jz && jz_taken)
              pc <= jump_target;
          end else if (op_swap) begin
            stk[0] <= stk[1];
            stk[1] <= stk[0];
          end else if (op_jmp) begin
            pc <= jump_target;
          end
        end
      end
    end
  end

  assign PROG_ADDR   = pc;
  assign OUT         = out_reg;
  assign OUT_STROBE  = strobe;
  assign HALTED      = (state == S_HALT);
  assign FAULT       = (state == S_FAULT);
  assign FAULT_CODE  = fault_code;
  assign STACK_COUNT = count;

endmodule

// File: tb/tb_stack_cpu_core.sv
// Bench for stack_cpu_core: directed and random programs run against a
// queue-based instruction-level model, with random ENABLE gaps and async resets.
module tb_stack_cpu_core;

  localparam int DATA_W      = 8;
  localparam int STACK_DEPTH = 4;
  localparam int PROG_AW     = 4;
  localparam int STEP_DIV    = 3;
  localparam int PROG_N      = 1 << PROG_AW;
  localparam int SC_W        = $clog2(STACK_DEPTH + 1);

  logic                CLK = 1'b0;
  logic                RESETN = 1'b0;
  logic                ENABLE = 1'b0;
  logic [PROG_AW-1:0]  PROG_ADDR;
  logic [7:0]          PROG_DATA;
  logic [DATA_W-1:0]   OUT;
  logic                OUT_STROBE;
  logic                HALTED;
  logic                FAULT;
  logic [1:0]          FAULT_CODE;
  logic [SC_W-1:0]     STACK_COUNT;

  logic [7:0] prog [PROG_N];

  int total = 0;
  int bad   = 0;

  // Reference model state: stack top is the back of the queue.
  int m_pc, m_out, m_strobe, m_state, m_code;
  int m_stk[$];

  stack_cpu_core #(
    .DATA_W(DATA_W), .STACK_DEPTH(STACK_DEPTH), .PROG_AW(PROG_AW), .STEP_DIV(STEP_DIV)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .ENABLE(ENABLE),
    .PROG_ADDR(PROG_ADDR), .PROG_DATA(PROG_DATA),
    .OUT(OUT), .OUT_STROBE(OUT_STROBE), .HALTED(HALTED), .FAULT(FAULT),
    .FAULT_CODE(FAULT_CODE), .STACK_COUNT(STACK_COUNT)
  );

  assign PROG_DATA = prog[PROG_ADDR];

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    m_pc = 0; m_out = 0; m_strobe = 0; m_state = 0; m_code = 0;
    m_stk.delete();
  endtask

  task automatic modelStep();
    int op, need, grows, illegal, nxt, a, b;
    m_strobe = 0;
    if (m_state != 0) return;
    op = int'(prog[m_pc]);
    need = 0; grows = 0; illegal = 0;
    if (op < 64) begin
      case (op)
        0, 1: ;
        2, 5: need = 1;
        3, 6: need = 2;
        4: begin need = 1; grows = 1; end
        default: illegal = 1;
      endcase
    end else if (op < 128) grows = 1;
    else if (op >= 192) need = 1;

    if (illegal != 0) begin m_state = 2; m_code = 3; return; end
    if (m_stk.size() < need) begin m_state = 2; m_code = 2; return; end
    if (grows != 0 && m_stk.size() == STACK_DEPTH) begin m_state = 2; m_code = 1; return; end
    if (op == 1) begin m_state = 1; return; end

    nxt = (m_pc + 1) % PROG_N;
    if (op == 2) begin m_out = m_stk.pop_back(); m_strobe = 1; end
    else if (op == 3) begin
      a = m_stk.pop_back(); b = m_stk.pop_back();
      m_stk.push_back((a + b) % (1 << DATA_W));
    end
    else if (op == 4) m_stk.push_back(m_stk[$]);
    else if (op == 5) void'(m_stk.pop_back());
    else if (op == 6) begin
      a = m_stk.pop_back(); b = m_stk.pop_back();
      m_stk.push_back(a); m_stk.push_back(b);
    end
    else if (op >= 64 && op < 128) m_stk.push_back(op - 64);
    else if (op >= 128 && op < 192) nxt = (op % 64) % PROG_N;
    else if (op >= 192) begin
      a = m_stk.pop_back();
      if (a == 0) nxt = (op % 64) % PROG_N;
    end
    m_pc = nxt;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_pc"},     32'(PROG_ADDR),   m_pc);
    checkOutput({tag, "_out"},    32'(OUT),         m_out);
    checkOutput({tag, "_strobe"}, 32'(OUT_STROBE),  m_strobe);
    checkOutput({tag, "_halted"}, 32'(HALTED),      32'(m_state == 1));
    checkOutput({tag, "_fault"},  32'(FAULT),       32'(m_state == 2));
    checkOutput({tag, "_code"},   32'(FAULT_CODE),  m_code);
    checkOutput({tag, "_count"},  32'(STACK_COUNT), m_stk.size());
  endtask

  // Asserts reset between clock edges so the outputs must clear without a clock.
  task automatic doReset();
    #2 RESETN = 1'b0;
    #1;
    checkOutput("rst_pc",     32'(PROG_ADDR),   0);
    checkOutput("rst_out",    32'(OUT),         0);
    checkOutput("rst_strobe", 32'(OUT_STROBE),  0);
    checkOutput("rst_halted", 32'(HALTED),      0);
    checkOutput("rst_fault",  32'(FAULT),       0);
    checkOutput("rst_code",   32'(FAULT_CODE),  0);
    checkOutput("rst_count",  32'(STACK_COUNT), 0);
    @(posedge CLK); #1;
    RESETN = 1'b1;
    modelReset();
  endtask

  // Each step costs STEP_DIV enabled cycles; disabled cycles in between must not count.
  task automatic applyStimulus(input int nsteps, input int reset_step);
    int gap;
    for (int s = 0; s < nsteps; s++) begin
      for (int k = 1; k <= STEP_DIV; k++) begin
        gap = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 7)) : 0;
        if (s == 1 && k == 2) gap = 7;
        ENABLE = 1'b0;
        repeat (gap) begin
          @(posedge CLK); #1;
          checkOutput("hold_pc",     32'(PROG_ADDR),  m_pc);
          checkOutput("hold_strobe", 32'(OUT_STROBE), 0);
          m_strobe = 0;
        end
        ENABLE = 1'b1;
        @(posedge CLK); #1;
        if (k < STEP_DIV) begin
          m_strobe = 0;
          checkOutput("wait_pc",     32'(PROG_ADDR),  m_pc);
          checkOutput("wait_strobe", 32'(OUT_STROBE), 0);
        end else begin
          modelStep();
          checkAll("step");
        end
      end
      if (s == reset_step) doReset();
    end
  endtask

  task automatic clearProg();
    for (int i = 0; i < PROG_N; i++) prog[i] = 8'h00;
  endtask

  function automatic logic [7:0] randOp();
    int r;
    r = $urandom_range(0, 99);
    if (r < 30)      return 8'(8'h40 | $urandom_range(0, 63));
    else if (r < 40) return 8'h03;
    else if (r < 48) return 8'h04;
    else if (r < 54) return 8'h05;
    else if (r < 60) return 8'h06;
    else if (r < 70) return 8'h02;
    else if (r < 78) return 8'(8'h80 | $urandom_range(0, 63));
    else if (r < 86) return 8'(8'hC0 | $urandom_range(0, 63));
    else if (r < 95) return 8'h00;
    else if (r < 97) return 8'h01;
    else             return 8'($urandom_range(7, 63));
  endfunction

  initial begin
    modelReset();
    clearProg();

    // PUSH 3; PUSH 4; ADD; OUT; HALT
    prog[0] = 8'h43; prog[1] = 8'h44; prog[2] = 8'h03; prog[3] = 8'h02; prog[4] = 8'h01;
    doReset();
    applyStimulus(6, -1);
    checkOutput("p1_out",    32'(OUT),         7);
    checkOutput("p1_halted", 32'(HALTED),      1);
    checkOutput("p1_pc",     32'(PROG_ADDR),   4);
    checkOutput("p1_count",  32'(STACK_COUNT), 0);

    // Taken JZ: PUSH 0; JZ 6; ...; PUSH 0x2A; OUT; HALT
    clearProg();
    prog[0] = 8'h40; prog[1] = 8'hC6; prog[2] = 8'h41; prog[3] = 8'h02; prog[4] = 8'h01;
    prog[6] = 8'h6A; prog[7] = 8'h02; prog[8] = 8'h01;
    doReset();
    applyStimulus(6, -1);
    checkOutput("jz_taken_out", 32'(OUT),       42);
    checkOutput("jz_taken_pc",  32'(PROG_ADDR), 8);

    // Not-taken JZ falls through to addr 2
    prog[0] = 8'h45;
    doReset();
    applyStimulus(6, -1);
    checkOutput("jz_fall_out", 32'(OUT),       1);
    checkOutput("jz_fall_pc",  32'(PROG_ADDR), 4);

    // Overflow at full depth on DUP
    clearProg();
    prog[0] = 8'h41; prog[1] = 8'h42; prog[2] = 8'h43; prog[3] = 8'h44; prog[4] = 8'h04;
    doReset();
    applyStimulus(7, -1);
    checkOutput("ovf_code",  32'(FAULT_CODE),  1);
    checkOutput("ovf_count", 32'(STACK_COUNT), 4);
    checkOutput("ovf_pc",    32'(PROG_ADDR),   4);

    // Underflow: DROP on empty stack
    clearProg();
    prog[0] = 8'h05;
    doReset();
    applyStimulus(3, -1);
    checkOutput("udf_code", 32'(FAULT_CODE), 2);

    // Illegal opcode
    prog[0] = 8'h07;
    doReset();
    applyStimulus(3, -1);
    checkOutput("ill_code", 32'(FAULT_CODE), 3);

    // Modular wrap: 63 -> 126 -> 252 -> 248
    clearProg();
    prog[0] = 8'h7F; prog[1] = 8'h04; prog[2] = 8'h03; prog[3] = 8'h04; prog[4] = 8'h03;
    prog[5] = 8'h04; prog[6] = 8'h03; prog[7] = 8'h02; prog[8] = 8'h01;
    doReset();
    applyStimulus(10, -1);
    checkOutput("wrap_out", 32'(OUT), 248);

    // PC wrap: PUSH 9, NOPs, OUT at 15, then back to 0; async reset mid-run
    clearProg();
    prog[0] = 8'h49; prog[15] = 8'h02;
    doReset();
    applyStimulus(17, -1);
    checkOutput("pcwrap_pc",  32'(PROG_ADDR), 1);
    checkOutput("pcwrap_out", 32'(OUT),       9);
    applyStimulus(4, 1);

    // Random programs
    for (int p = 0; p < 12; p++) begin
      for (int i = 0; i < PROG_N; i++) prog[i] = randOp();
      doReset();
      applyStimulus(24, (p % 4 == 0) ? 10 : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
